// File: rtl/usb2_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb2_rx_pkg
// Shared definitions for the USB 2.0 HS receive path (and the TX bit stuffer,
// which imports USB_STUFF_LEN so both directions agree on the run length).
//
// Contents:
//   rx_state_e     : bit-unstuffer state (IDLE, ACTIVE, DROP, ERR)
//   USB_STUFF_LEN  : number of consecutive 1s after which a 0 is stuffed
// -----------------------------------------------------------------------------
package usb2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for rx_active
        ACTIVE = 2'd1,  // passing bits, counting the current run of 1s
        DROP   = 2'd2,  // run complete, next valid bit must be a stuffed 0
        ERR    = 2'd3   // violation seen, rest of packet discarded
    } rx_state_e;

    localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/bit_unstuffer_if.sv
// -----------------------------------------------------------------------------
// bit_unstuffer_if
// Bit-stream bundle between the NRZI decoder, the bit unstuffer and the RX
// byte deserializer.
//
// Signals:
//   rx_active  : packet window from the SYNC detector
//   din        : NRZI-decoded bit
//   din_valid  : din qualifier (no backpressure)
//   dout       : unstuffed bit
//   dout_valid : dout qualifier
//   dout_end   : one-cycle packet-end pulse
//   stuffed    : one-cycle pulse when a stuffed 0 is dropped
//   stuff_err  : one-cycle pulse on a stuff violation
//   eop_det    : one-cycle HS EOP pulse (only with BIT_UNSTUFFER_HS_EOP_EN)
//
// Modports:
//   master : upstream side, drives the input stream and observes the results
//   slave  : the unstuffer itself
//
// Build option: BIT_UNSTUFFER_HS_EOP_EN adds eop_det.
// -----------------------------------------------------------------------------
interface bit_unstuffer_if;

    logic rx_active;
    logic din;
    logic din_valid;
    logic dout;
    logic dout_valid;
    logic dout_end;
    logic stuffed;
    logic stuff_err;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
    logic eop_det;

    modport master (
        output rx_active, din, din_valid,
        input  dout, dout_valid, dout_end, stuffed, stuff_err, eop_det
    );

    modport slave (
        input  rx_active, din, din_valid,
        output dout, dout_valid, dout_end, stuffed, stuff_err, eop_det
    );
`else
    modport master (
        output rx_active, din, din_valid,
        input  dout, dout_valid, dout_end, stuffed, stuff_err
    );

    modport slave (
        input  rx_active, din, din_valid,
        output dout, dout_valid, dout_end, stuffed, stuff_err
    );
`endif

endinterface

// File: rtl/bit_unstuffer.sv
// -----------------------------------------------------------------------------
// bit_unstuffer
// HS receive-path block: removes the 0 stuffed after every run of STUFF_LEN
// consecutive 1s, flags stuff violations and marks packet end. One bit per
// clock at most; all outputs registered, din -> dout latency is one cycle.
//
// Ports:
//   clk  : 480 MHz bit clock
//   rst  : synchronous reset, active-high
//   bus  : bit_unstuffer_if.slave (rx_active/din/din_valid in,
//          dout/dout_valid/dout_end/stuffed/stuff_err[/eop_det] out)
//
// Parameters:
//   STUFF_LEN : 1-run length after which one 0 is expected and dropped (2..15)
//
// Build option:
//   BIT_UNSTUFFER_HS_EOP_EN : a violation in DROP is an HS EOP and pulses
//                             eop_det instead of stuff_err.
// -----------------------------------------------------------------------------
module bit_unstuffer
    import usb2_rx_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic            clk,
    input  logic            rst,
    bit_unstuffer_if.slave  bus
);

    localparam int              CNT_W     = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0] STUFF_MAX = CNT_W'(STUFF_LEN);

    rx_state_e        state_q,      state_d;
    logic [CNT_W-1:0] ones_cnt_q,   ones_cnt_d;
    logic [CNT_W-1:0] ones_cnt_inc;
    logic             dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_end_q,   dout_end_d;
    logic             stuffed_q,    stuffed_d;
    logic             stuff_err_q,  stuff_err_d;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
    logic             eop_det_q,    eop_det_d;
`endif

    // Saturating increment: the counter parks at STUFF_MAX instead of wrapping.
    assign ones_cnt_inc = (ones_cnt_q == STUFF_MAX) ? ones_cnt_q
                                                    : ones_cnt_q + CNT_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        dout_end_d   = 1'b0;
        stuffed_d    = 1'b0;
        stuff_err_d  = 1'b0;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
        eop_det_d    = 1'b0;
`endif

        // rx_active is high on entry to every non-IDLE state, so a low level
        // here is the falling edge. It overrides any din_valid in the cycle,
        // and a pending stuffed 0 in DROP is simply no longer expected.
        if (state_q != IDLE && !bus.rx_active) begin
            state_d    = IDLE;
            ones_cnt_d = '0;
            dout_end_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_active) begin
                        state_d    = ACTIVE;
                        ones_cnt_d = '0;
                    end
                end

                ACTIVE: begin
                    if (bus.din_valid) begin
                        dout_d       = bus.din;
                        dout_valid_d = 1'b1;
                        if (bus.din) begin
                            ones_cnt_d = ones_cnt_inc;
                            if (ones_cnt_inc == STUFF_MAX) begin
                                state_d = DROP;
                            end
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end
                end

                DROP: begin
                    if (bus.din_valid) begin
                        if (!bus.din) begin
                            stuffed_d  = 1'b1;
                            ones_cnt_d = '0;
                            state_d    = ACTIVE;
                        end else begin
`ifdef BIT_UNSTUFFER_HS_EOP_EN
                            eop_det_d   = 1'b1;
`else
                            stuff_err_d = 1'b1;
`endif
                            state_d     = ERR;
                        end
                    end
                end

                ERR: begin
                    // Discard everything until rx_active falls.
                end

                default: begin
                    state_d    = IDLE;
                    ones_cnt_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ones_cnt_q   <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_end_q   <= 1'b0;
            stuffed_q    <= 1'b0;
            stuff_err_q  <= 1'b0;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
            eop_det_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_end_q   <= dout_end_d;
            stuffed_q    <= stuffed_d;
            stuff_err_q  <= stuff_err_d;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
            eop_det_q    <= eop_det_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_end   = dout_end_q;
    assign bus.stuffed    = stuffed_q;
    assign bus.stuff_err  = stuff_err_q;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
    assign bus.eop_det    = eop_det_q;
`endif

endmodule

// File: tb/tb_bit_unstuffer.sv
// -----------------------------------------------------------------------------
// tb_bit_unstuffer
// Self-checking bench for bit_unstuffer (STUFF_LEN = 6). Each cycle's inputs
// are paired with the outputs expected one clock later; the expectation is
// queued when the inputs are driven and compared after the edge.
// Honours BIT_UNSTUFFER_HS_EOP_EN (violation expected on eop_det instead).
// -----------------------------------------------------------------------------
module tb_bit_unstuffer;
    import usb2_rx_pkg::*;

    typedef struct packed {
        logic dout;
        logic dout_valid;
        logic dout_end;
        logic stuffed;
        logic stuff_err;
        logic eop_det;
    } out_t;

    typedef struct {
        string name;
        logic  rst;
        logic  ra;
        logic  din;
        logic  dv;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bit_unstuffer_if bus ();

    bit_unstuffer #(.STUFF_LEN(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    // Expected output record; viol is the violation pulse, which lands on
    // eop_det or stuff_err depending on the build.
    function automatic out_t o(logic d, logic dv, logic e, logic s, logic viol);
        out_t r = '0;
        r.dout       = d;
        r.dout_valid = dv;
        r.dout_end   = e;
        r.stuffed    = s;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
        r.eop_det    = viol;
`else
        r.stuff_err  = viol;
`endif
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.dout       = bus.dout;
        r.dout_valid = bus.dout_valid;
        r.dout_end   = bus.dout_end;
        r.stuffed    = bus.stuffed;
        r.stuff_err  = bus.stuff_err;
`ifdef BIT_UNSTUFFER_HS_EOP_EN
        r.eop_det    = bus.eop_det;
`else
        r.eop_det    = 1'b0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {dout,dv,end,stuffed,err,eop}=%b expected %b",
                     name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected result, compare after edge.
    task automatic step(input string name, input logic r, input logic ra,
                        input logic d, input logic dv, input out_t e);
        rst           = r;
        bus.rx_active = ra;
        bus.din       = d;
        bus.din_valid = dv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, sample(), exp_q.pop_front());
        end
    endtask

    task automatic ones(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step($sformatf("%s one%0d", tag, i), 1'b0, 1'b1, 1'b1, 1'b1, o(1, 1, 0, 0, 0));
    endtask

    function automatic void add(input string name, input logic r, input logic ra,
                                input logic d, input logic dv, input out_t e);
        vec_t v;
        v.name = name; v.rst = r; v.ra = ra; v.din = d; v.dv = dv; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [4:0] basic_bits;
        logic [7:0] gap_bits;
        out_t       z;
        z          = '0;
        basic_bits = 5'b01101;      // sent LSB first: 1,0,1,1,0
        gap_bits   = 8'b10111111;   // sent LSB first: six 1s, 0, 1

        // ---------------- table: pass-through, stuff removal, gaps ----------
        add("reset", 1, 0, 0, 0, z);
        add("reset with traffic", 1, 1, 1, 1, z);
        add("idle ignores din", 0, 0, 1, 1, z);

        add("basic start ignores din", 0, 1, 1, 1, z);
        for (int i = 0; i < 5; i++)
            add($sformatf("basic bit%0d", i), 0, 1, basic_bits[i], 1,
                o(basic_bits[i], 1, 0, 0, 0));
        add("basic end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        add("basic idle", 0, 0, 0, 0, z);

        add("stuff start", 0, 1, 0, 0, z);
        for (int i = 0; i < 6; i++)
            add($sformatf("stuff one%0d", i), 0, 1, 1, 1, o(1, 1, 0, 0, 0));
        add("stuff drop 0", 0, 1, 0, 1, o(0, 0, 0, 1, 0));
        add("stuff tail 1", 0, 1, 1, 1, o(1, 1, 0, 0, 0));
        add("stuff end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        add("stuff idle", 0, 0, 0, 0, z);

        add("gap start", 0, 1, 0, 0, z);
        for (int i = 0; i < 8; i++) begin
            if (i == 6)
                add($sformatf("gap bit%0d", i), 0, 1, gap_bits[i], 1, o(0, 0, 0, 1, 0));
            else
                add($sformatf("gap bit%0d", i), 0, 1, gap_bits[i], 1,
                    o(gap_bits[i], 1, 0, 0, 0));
            add($sformatf("gap hole%0d", i), 0, 1, 0, 0, z);
        end
        add("gap end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        add("gap idle", 0, 0, 0, 0, z);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].name, vecs[i].rst, vecs[i].ra, vecs[i].din, vecs[i].dv, vecs[i].exp);

        // ---------------- violation: seven 1s ----------------
        step("viol start", 0, 1, 0, 0, z);
        ones("viol", 6);
        step("viol seventh 1", 0, 1, 1, 1, o(0, 0, 0, 0, 1));
        step("err discard 1", 0, 1, 1, 1, z);
        step("err discard 0", 0, 1, 0, 1, z);
        step("err no valid", 0, 1, 0, 0, z);
        step("err end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        step("err idle", 0, 0, 0, 0, z);

        // ---------------- packet end in DROP, then back-to-back packet -------
        step("drop start", 0, 1, 0, 0, z);
        ones("drop", 6);
        step("drop fall discards 0", 0, 0, 0, 1, o(0, 0, 1, 0, 0));
        step("rise after fall", 0, 1, 0, 0, z);
        step("next pkt 1", 0, 1, 1, 1, o(1, 1, 0, 0, 0));
        step("next pkt 0", 0, 1, 0, 1, o(0, 1, 0, 0, 0));
        ones("run5", 5);
        step("active fall discards 1", 0, 0, 1, 1, o(0, 0, 1, 0, 0));
        step("rise again", 0, 1, 0, 0, z);
        step("cnt cleared 1", 0, 1, 1, 1, o(1, 1, 0, 0, 0));
        step("cnt cleared 0", 0, 1, 0, 1, o(0, 1, 0, 0, 0));
        step("pkt end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        step("pkt idle", 0, 0, 0, 0, z);

        // ---------------- reset mid-packet ----------------
        step("rst start", 0, 1, 0, 0, z);
        ones("pre-rst", 3);
        step("rst mid packet", 1, 1, 1, 1, z);
        step("no dout_end after rst", 0, 0, 0, 0, z);
        step("post-rst start", 0, 1, 0, 0, z);
        ones("post-rst", 5);
        step("post-rst 0 no drop", 0, 1, 0, 1, o(0, 1, 0, 0, 0));
        step("post-rst end", 0, 0, 0, 0, o(0, 0, 1, 0, 0));
        step("post-rst idle", 0, 0, 0, 0, z);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
